// File: rtl/pcie_msi_irq_ctrl.sv
// pcie_msi_irq_ctrl: latches rising edges of user interrupt lines and serves them round-robin as pcie_7x MSI requests.
// Optional MSI_IRQ_MASK_EN adds an i_irq_mask input that hides pending sources from arbitration.
module pcie_msi_irq_ctrl #(
    parameter int N_IRQ       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] i_irq_in,
    input  logic             i_msi_enable,
    input  logic [2:0]       i_msi_vector_width,
    input  logic             i_intx_msi_grant,
`ifdef MSI_IRQ_MASK_EN
    input  logic [N_IRQ-1:0] i_irq_mask,
`endif
    output logic             o_intx_msi_request,
    output logic [4:0]       o_msi_vector_num,
    output logic [N_IRQ-1:0] o_irq_pending
);
    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
    state_t           r_state;
    logic [N_IRQ-1:0] r_sync [SYNC_STAGES];
    logic [N_IRQ-1:0] r_prev, r_pending, w_rise, w_clr, w_elig;
    logic [4:0]       r_rr, r_idx, r_vec, w_pick, w_vec_max, w_vec;
    logic [2:0]       w_log;
    logic [5:0]       w_j;
    logic             r_req;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end
    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_clr  = (r_state == REQ && i_intx_msi_grant) ? N_IRQ'(1) << r_idx : '0;
`ifdef MSI_IRQ_MASK_EN
    assign w_elig = r_pending & ~i_irq_mask;
`else
    assign w_elig = r_pending;
`endif
    // Descending scan so the last hit is the nearest eligible index at or after the pointer.
    always_comb begin
        w_pick = r_rr;
        w_j    = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            w_j = {1'b0, r_rr} + 6'(k);
            if (w_j >= 6'(N_IRQ)) w_j = w_j - 6'(N_IRQ);
            if (w_elig[w_j[4:0]]) w_pick = w_j[4:0];
        end
    end
    assign w_log     = (i_msi_vector_width > 3'd5) ? 3'd5 : i_msi_vector_width;
    assign w_vec_max = 5'((6'd1 << w_log) - 6'd1);
    assign w_vec     = (w_pick <= w_vec_max) ? w_pick : w_vec_max;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pending <= '0;
        else     r_pending <= (r_pending & ~w_clr) | w_rise;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_vec   <= '0;
            r_idx   <= '0;
            r_rr    <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_msi_enable && |w_elig) begin
                    r_idx   <= w_pick;
                    r_vec   <= w_vec;
                    r_req   <= 1'b1;
                    r_state <= REQ;
                end
                // Only a grant ends a request; enable and mask changes are ignored here.
                REQ: if (i_intx_msi_grant) begin
                    r_req   <= 1'b0;
                    r_rr    <= (r_idx == 5'(N_IRQ - 1)) ? '0 : r_idx + 5'd1;
                    r_state <= GAP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign o_intx_msi_request = r_req;
    assign o_msi_vector_num   = r_vec;
    assign o_irq_pending      = r_pending;
endmodule
